// File: rtl/noc_pkg.sv
// Shared definitions for the 4-node bidirectional ring NoC router.
package noc_pkg;

  typedef enum logic [1:0] {
    PORT_E = 2'd0,
    PORT_W = 2'd1,
    PORT_L = 2'd2
  } port_t;

  localparam int unsigned ID_W      = 2;
  localparam int unsigned NUM_NODES = 4;
  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned AF_MARGIN = 2;

  // Shortest-path direction from node id to dest; distance 2 goes East.
  function automatic port_t route(input logic [ID_W-1:0] dest, input logic [ID_W-1:0] id);
    logic [ID_W-1:0] d;
    d = dest - id;
    case (d)
      2'd0:    return PORT_L;
      2'd3:    return PORT_W;
      default: return PORT_E;
    endcase
  endfunction

  // (base + k) mod 3 over the port numbering.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Round-robin pointer position just past the granted port.
  function automatic port_t rr_next(input port_t p);
    case (p)
      PORT_E:  return PORT_W;
      PORT_W:  return PORT_L;
      default: return PORT_E;
    endcase
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/almost-full.
module noc_fifo
  import noc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid,
  output logic             o_full,
  output logic             o_almost_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_almost_full;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic [CW-1:0]    w_count_next;

  // A pop in the same cycle frees the slot, so a push to a full FIFO is then accepted.
  always_comb begin
    w_pop_ok  = i_pop && (r_count != '0);
    w_push_ok = i_push && ((r_count != FULL_CNT) || w_pop_ok);
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count       <= w_count_next;
      r_full        <= (w_count_next == FULL_CNT);
      r_almost_full <= (w_count_next >= AF_CNT);
    end
  end

  // Storage array; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head        = r_mem[r_rd_ptr];
  assign o_valid       = (r_count != '0);
  assign o_full        = r_full;
  assign o_almost_full = r_almost_full;

endmodule

// File: rtl/noc_ring_router.sv
// Three-port (E/W/L) store-and-forward ring router node with per-output RR arbitration.
module noc_ring_router
  import noc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned ID    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeE,
  input  logic             writeW,
  input  logic             writeL,
  input  logic             read_FullE,
  input  logic             read_FullW,
  input  logic             read_FullL,
  input  logic             read_almostFullE,
  input  logic             read_almostFullW,
  input  logic             read_almostFullL,
  input  logic [WIDTH-1:0] dataInE,
  input  logic [WIDTH-1:0] dataInW,
  input  logic [WIDTH-1:0] dataInL,
  output logic [WIDTH-1:0] dataOutE,
  output logic [WIDTH-1:0] dataOutW,
  output logic [WIDTH-1:0] dataOutL,
  output logic             writeOutE,
  output logic             writeOutW,
  output logic             writeOutL,
  output logic             fullE,
  output logic             fullW,
  output logic             fullL,
  output logic             almost_fullE,
  output logic             almost_fullW,
  output logic             almost_fullL
);

  localparam logic [ID_W-1:0] MY_ID = ID[ID_W-1:0];

  logic [2:0]       w_push;
  logic [WIDTH-1:0] w_din    [NUM_PORTS];
  logic [WIDTH-1:0] w_head   [NUM_PORTS];
  logic [2:0]       w_valid;
  logic [2:0]       w_full;
  logic [2:0]       w_af;
  logic [2:0]       w_pop;
  logic [2:0]       w_blocked;
  port_t            w_route  [NUM_PORTS];
  logic [2:0]       w_req    [NUM_PORTS];
  logic [2:0]       w_gnt_vld;
  port_t            w_gnt_src[NUM_PORTS];

  port_t            r_ptr    [NUM_PORTS];
  logic [WIDTH-1:0] r_dout   [NUM_PORTS];
  logic [2:0]       r_wout;

  assign w_push    = {writeL, writeW, writeE};
  assign w_din[0]  = dataInE;
  assign w_din[1]  = dataInW;
  assign w_din[2]  = dataInL;
  assign w_blocked = {read_FullL | read_almostFullL,
                      read_FullW | read_almostFullW,
                      read_FullE | read_almostFullE};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
    noc_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .i_push        (w_push[g]),
      .i_din         (w_din[g]),
      .i_pop         (w_pop[g]),
      .o_head        (w_head[g]),
      .o_valid       (w_valid[g]),
      .o_full        (w_full[g]),
      .o_almost_full (w_af[g])
    );
  end

  // Route decode of every FIFO head and per-output request vectors.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_route[i] = route(w_head[i][WIDTH-1 -: ID_W], MY_ID);
    end
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      w_req[o] = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        w_req[o][i] = w_valid[i] && (2'(w_route[i]) == 2'(o));
      end
    end
  end

  // Round-robin arbiters: search from the pointer in E->W->L order; a blocked output grants nothing.
  always_comb begin
    logic [1:0] idx;
    idx = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      w_gnt_vld[o] = 1'b0;
      w_gnt_src[o] = r_ptr[o];
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        idx = rr_idx(2'(r_ptr[o]), 2'(k));
        if (!w_gnt_vld[o] && !w_blocked[o] && w_req[o][idx]) begin
          w_gnt_vld[o] = 1'b1;
          w_gnt_src[o] = port_t'(idx);
        end
      end
    end
  end

  // Each head routes to exactly one output, so at most one grant can target a FIFO.
  always_comb begin
    w_pop = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (w_gnt_vld[o] && (2'(w_gnt_src[o]) == 2'(i))) w_pop[i] = 1'b1;
      end
    end
  end

  // Output registers and arbiter pointers; data holds while no word is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wout <= '0;
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        r_ptr[o]  <= PORT_E;
        r_dout[o] <= '0;
      end
    end else begin
      r_wout <= w_gnt_vld;
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        if (w_gnt_vld[o]) begin
          r_dout[o] <= w_head[w_gnt_src[o]];
          r_ptr[o]  <= rr_next(w_gnt_src[o]);
        end
      end
    end
  end

  assign dataOutE     = r_dout[0];
  assign dataOutW     = r_dout[1];
  assign dataOutL     = r_dout[2];
  assign writeOutE    = r_wout[0];
  assign writeOutW    = r_wout[1];
  assign writeOutL    = r_wout[2];
  assign fullE        = w_full[0];
  assign fullW        = w_full[1];
  assign fullL        = w_full[2];
  assign almost_fullE = w_af[0];
  assign almost_fullW = w_af[1];
  assign almost_fullL = w_af[2];

endmodule

// File: tb/tb_noc_ring_router.sv
// Scoreboard bench for noc_ring_router (WIDTH=16, DEPTH=32, ID=0).
module tb_noc_ring_router;

  logic        clk = 1'b0;
  logic        reset;
  logic        writeE, writeW, writeL;
  logic        read_FullE, read_FullW, read_FullL;
  logic        read_almostFullE, read_almostFullW, read_almostFullL;
  logic [15:0] dataInE, dataInW, dataInL;
  logic [15:0] dataOutE, dataOutW, dataOutL;
  logic        writeOutE, writeOutW, writeOutL;
  logic        fullE, fullW, fullL;
  logic        almost_fullE, almost_fullW, almost_fullL;

  int n_checks = 0;
  int n_errors = 0;

  // Expected words per (output*3 + source) stream, in push order.
  logic [15:0] sb [9][$];

  noc_ring_router #(
    .WIDTH(16),
    .DEPTH(32),
    .ID(0)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .writeE           (writeE),
    .writeW           (writeW),
    .writeL           (writeL),
    .read_FullE       (read_FullE),
    .read_FullW       (read_FullW),
    .read_FullL       (read_FullL),
    .read_almostFullE (read_almostFullE),
    .read_almostFullW (read_almostFullW),
    .read_almostFullL (read_almostFullL),
    .dataInE          (dataInE),
    .dataInW          (dataInW),
    .dataInL          (dataInL),
    .dataOutE         (dataOutE),
    .dataOutW         (dataOutW),
    .dataOutL         (dataOutL),
    .writeOutE        (writeOutE),
    .writeOutW        (writeOutW),
    .writeOutL        (writeOutL),
    .fullE            (fullE),
    .fullW            (fullW),
    .fullL            (fullL),
    .almost_fullE     (almost_fullE),
    .almost_fullW     (almost_fullW),
    .almost_fullL     (almost_fullL)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Output index (E=0, W=1, L=2) for node 0.
  function automatic int route_of(input logic [15:0] w);
    case (w[15:14])
      2'd0:    return 2;
      2'd3:    return 1;
      default: return 0;
    endcase
  endfunction

  task automatic sb_take(input int o, input logic [15:0] d);
    int hit;
    hit = 0;
    for (int s = 0; s < 3; s++) begin
      if (hit == 0 && sb[o*3+s].size() > 0 && sb[o*3+s][0] == d) begin
        void'(sb[o*3+s].pop_front());
        hit = 1;
      end
    end
    chk($sformatf("sb_out%0d_%h", o, d), hit, 1);
  endtask

  function automatic int sb_total();
    int t;
    t = 0;
    for (int q = 0; q < 9; q++) t += sb[q].size();
    return t;
  endfunction

  // Output monitor: every issued word must be the oldest pending word of some stream.
  always @(negedge clk) begin
    if (!reset) begin
      if (writeOutE) sb_take(0, dataOutE);
      if (writeOutW) sb_take(1, dataOutW);
      if (writeOutL) sb_take(2, dataOutL);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    writeE = 1'b0; writeW = 1'b0; writeL = 1'b0;
  endtask

  task automatic drive(input int s, input logic [15:0] d, input bit kept);
    case (s)
      0: begin writeE = 1'b1; dataInE = d; end
      1: begin writeW = 1'b1; dataInW = d; end
      default: begin writeL = 1'b1; dataInL = d; end
    endcase
    if (kept) sb[route_of(d)*3+s].push_back(d);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wout"}, {writeOutE, writeOutW, writeOutL}, 3'b000);
    chk({tag, "_full"}, {fullE, fullW, fullL}, 3'b000);
    chk({tag, "_af"}, {almost_fullE, almost_fullW, almost_fullL}, 3'b000);
    chk({tag, "_doE"}, dataOutE, 16'h0);
    chk({tag, "_doW"}, dataOutW, 16'h0);
    chk({tag, "_doL"}, dataOutL, 16'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int got;
    logic [3:0] prev;
    int wait_cyc;

    reset = 1'b1;
    clear_in();
    dataInE = '0; dataInW = '0; dataInL = '0;
    read_FullE = 0; read_FullW = 0; read_FullL = 0;
    read_almostFullE = 0; read_almostFullW = 0; read_almostFullL = 0;
    repeat (3) tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Local delivery latency and single-cycle strobe.
    drive(2, 16'h0123, 1);
    tick();
    clear_in();
    chk("lat_n0", writeOutL, 1'b0);
    tick();
    chk("lat_n1", writeOutL, 1'b1);
    chk("lat_d1", dataOutL, 16'h0123);
    tick();
    chk("lat_n2", writeOutL, 1'b0);
    chk("hold_d", dataOutL, 16'h0123);

    // Direction decode for dest 1, 3, 2.
    drive(2, 16'h4005, 1); tick(); clear_in(); tick();
    chk("rt_d1_we", writeOutE, 1'b1);
    chk("rt_d1_de", dataOutE, 16'h4005);
    drive(2, 16'hC007, 1); tick(); clear_in(); tick();
    chk("rt_d3_ww", writeOutW, 1'b1);
    chk("rt_d3_dw", dataOutW, 16'hC007);
    drive(2, 16'h8009, 1); tick(); clear_in(); tick();
    chk("rt_d2_we", writeOutE, 1'b1);
    chk("rt_d2_de", dataOutE, 16'h8009);
    tick();

    // Backpressure fill: 33 words on L toward E while E is almost full.
    read_almostFullE = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      drive(2, 16'h4000 + 16'(i), i <= 32);
      tick();
      clear_in();
      chk("bp_hold", writeOutE, 1'b0);
      if (i == 29) chk("af_29", almost_fullL, 1'b0);
      if (i == 30) chk("af_30", almost_fullL, 1'b1);
      if (i == 31) chk("full_31", fullL, 1'b0);
      if (i == 32) chk("full_32", fullL, 1'b1);
      if (i == 33) chk("full_33", fullL, 1'b1);
    end
    read_almostFullE = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("drain_we", writeOutE, 1'b1);
    end
    tick();
    chk("drain_end", writeOutE, 1'b0);
    chk("drain_full", fullL, 1'b0);
    chk("drain_af", almost_fullL, 1'b0);

    // Two dest-0 streams merge onto L, alternating source every cycle.
    got = 0;
    prev = '0;
    for (int c = 0; c < 60 && got < 32; c++) begin
      clear_in();
      if (c < 16) begin
        drive(0, 16'h0100 + 16'(c), 1);
        drive(1, 16'h0200 + 16'(c), 1);
      end
      tick();
      if (got > 0 && got < 32) chk("merge_contig", writeOutL, 1'b1);
      if (writeOutL) begin
        if (got > 0) chk("merge_alt", dataOutL[11:8] != prev, 1'b1);
        prev = dataOutL[11:8];
        got++;
      end
    end
    clear_in();
    chk("merge_count", got, 32);
    tick();

    // Three concurrent non-conflicting streams keep all outputs busy.
    for (int c = 0; c < 20; c++) begin
      clear_in();
      drive(2, 16'h4300 + 16'(c), 1);
      drive(0, 16'h0400 + 16'(c), 1);
      drive(1, 16'hC500 + 16'(c), 1);
      tick();
      if (c >= 1) chk("conc_all", {writeOutE, writeOutW, writeOutL}, 3'b111);
    end
    clear_in();
    tick();
    chk("conc_last", {writeOutE, writeOutW, writeOutL}, 3'b111);
    tick();
    chk("conc_idle", {writeOutE, writeOutW, writeOutL}, 3'b000);

    wait_cyc = 0;
    while (sb_total() != 0 && wait_cyc < 100) begin
      tick();
      wait_cyc++;
    end
    chk("sb_empty", sb_total(), 0);

    // Mid-stream reset: queued words are discarded and outputs clear at once.
    read_almostFullL = 1'b1;
    for (int c = 0; c < 5; c++) begin
      clear_in();
      drive(0, 16'h0600 + 16'(c), 1);
      drive(2, 16'h4700 + 16'(c), 1);
      tick();
    end
    clear_in();
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("mid");
    for (int q = 0; q < 9; q++) sb[q].delete();
    tick();
    reset = 1'b0;
    read_almostFullL = 1'b0;
    repeat (6) begin
      tick();
      chk("post_rst_idle", {writeOutE, writeOutW, writeOutL}, 3'b000);
    end
    drive(2, 16'h0AAA, 1); tick(); clear_in(); tick();
    chk("post_rst_wl", writeOutL, 1'b1);
    chk("post_rst_dl", dataOutL, 16'h0AAA);
    tick();
    chk("final_empty", sb_total(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
